div_4bit_seq: RTL and testbench

Sequential restoring divider that computes the quotient and remainder of two unsigned WIDTH-bit operands. It resolves one quotient bit per clock using a subtract-and-restore step, which is the subtract mode of the existing 4-bit add/sub datapath applied iteratively. It sits beside the combinational add/sub in the arithmetic group as its multi-cycle counterpart. A start/busy/done handshake lets a controller or bench launch one operation at a time.

---
 rtl/div_4bit_seq.sv | 106 ++++++++++
 tb/tb_div_4bit_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_4bit_seq.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per operation.
// A start/busy/done handshake launches one division at a time; results hold until the next completion.
module div_4bit_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CW-1:0]    count;

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;

   // One extra guard bit keeps the sign test exact; A < M always holds, so it never overflows.
   always_comb begin
      shifted = {a, q[WIDTH-1]};
      trial   = shifted - {2'b00, m};
      a_next  = shifted[WIDTH:0];
      q_next  = {q[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH+1]) begin
         a_next = trial[WIDTH:0];
         q_next = {q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               state <= IDLE;
               if (start) begin
                  a           <= '0;
                  q           <= dividend;
                  m           <= divisor;
                  count       <= CW'(WIDTH);
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               a     <= a_next;
               q     <= q_next;
               count <= count - CW'(1);
               // Last iteration publishes results straight from the next-state values.
               if (count == CW'(1)) begin
                  quotient  <= q_next;
                  remainder <= a_next[WIDTH-1:0];
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_4bit_seq.sv
// Self-checking bench for div_4bit_seq: directed table, handshake corner cases, exhaustive and random sweeps.
module tb_div_4bit_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] dd;
      logic [W-1:0] dv;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t table_v[6];

   div_4bit_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain arithmetic reference, with the all-ones / dividend rule for a zero divisor.
   function automatic vec_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
      vec_t v;
      v.dd = dd;
      v.dv = dv;
      if (dv == 0) begin
         v.q   = '1;
         v.r   = dd;
         v.dz  = 1'b1;
         v.lat = 0;
      end else begin
         v.q   = W'(int'(dd) / int'(dv));
         v.r   = W'(int'(dd) % int'(dv));
         v.dz  = 1'b0;
         v.lat = W;
      end
      return v;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge (cyc = 0).
   task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] dv);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      dividend = W'($urandom_range(0, 15));
      divisor  = W'($urandom_range(0, 15));
      cyc      = 0;
   endtask

   task automatic wait_done(input vec_t v, input string name);
      while (!done && cyc < 20) begin
         check({name, " busy"}, int'(busy), (v.lat != 0) ? 1 : 0);
         @(negedge clk);
         cyc++;
      end
      check({name, " done"}, int'(done), 1);
      check({name, " latency"}, cyc, v.lat);
      check({name, " quotient"}, int'(quotient), int'(v.q));
      check({name, " remainder"}, int'(remainder), int'(v.r));
      check({name, " div_by_zero"}, int'(div_by_zero), int'(v.dz));
      check({name, " busy at done"}, int'(busy), 0);
   endtask

   task automatic idle_check(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({name, " done low"}, int'(done), 0);
         check({name, " busy low"}, int'(busy), 0);
      end
   endtask

   initial begin
      table_v[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0, lat: 4};
      table_v[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 4};
      table_v[2] = '{dd: 4'd3,  dv: 4'd12, q: 4'd0,  r: 4'd3, dz: 1'b0, lat: 4};
      table_v[3] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 4};
      table_v[4] = '{dd: 4'd9,  dv: 4'd0,  q: 4'hF,  r: 4'd9, dz: 1'b1, lat: 0};
      table_v[5] = '{dd: 4'd8,  dv: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0, lat: 4};

      // Clock/reset
      repeat (2) @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         launch(table_v[i].dd, table_v[i].dv);
         wait_done(table_v[i], $sformatf("table[%0d]", i));
         idle_check(1, $sformatf("table[%0d] after", i));
      end

      // A start during RUN is ignored
      launch(4'd13, 4'd3);
      @(negedge clk);
      cyc++;
      start    = 1'b1;
      dividend = 4'd6;
      divisor  = 4'd2;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      wait_done(table_v[0], "ignored start");

      // Back-to-back: start accepted in the DONE cycle
      launch(4'd6, 4'd2);
      check("b2b done falls", int'(done), 0);
      check("b2b busy rises", int'(busy), 1);
      wait_done(model(4'd6, 4'd2), "back-to-back");
      idle_check(1, "b2b after");

      // Asynchronous reset mid-operation
      launch(4'd14, 4'd4);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort quotient", int'(quotient), 0);
      check("abort remainder", int'(remainder), 0);
      check("abort div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      idle_check(6, "abort no done");
      launch(4'd14, 4'd4);
      wait_done(model(4'd14, 4'd4), "after abort");
      idle_check(1, "after abort idle");

      // Exhaustive sweep; randomly chain back-to-back or insert idle gaps
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            launch(W'(a), W'(b));
            wait_done(model(W'(a), W'(b)), $sformatf("exh %0d/%0d", a, b));
            if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 2), "exh gap");
         end
      end

      // Random operations
      for (int k = 0; k < 60; k++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom_range(0, 15));
         rb = W'($urandom_range(0, 15));
         launch(ra, rb);
         wait_done(model(ra, rb), $sformatf("rand %0d/%0d", ra, rb));
         if ($urandom_range(0, 2) == 0) idle_check(1, "rand gap");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Handshake property watched throughout the run
   always @(negedge clk) begin
      if (!rst && busy && done) begin
         n_vec++;
         n_fail++;
         $display("FAIL busy_done_overlap: busy=%0d done=%0d, expected never both high (t=%0t)", busy, done, $time);
      end
   end

endmodule
